// File: rtl/instr_dispatch_ctrl.sv
// Decodes HPS PIO instruction words into a pixel write, a framebuffer clear or an algorithm launch. Optional build macro: PIXEL_BOUNDS_CHECK_EN.
// Latency: the FSM enters DECODE on the edge after start rises. A WRITE pulses mem_wr_en in the next cycle, and done is high one edge after that.
// Backpressure: a 4-phase handshake. done is held until start drops, and any start rise outside IDLE is ignored.
module instr_dispatch_ctrl #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 8,
    parameter int IMG_PIXELS = 19200,
    parameter int ALGO_W     = 3
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [31:0]       instruct,
    input  logic              start,
    output logic              done,
    output logic              donewrite,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              algo_start,
    output logic [ALGO_W-1:0] algo_sel,
    input  logic              algo_done,
    output logic              busy,
    output logic              err
);

    localparam logic [2:0] OP_WRITE = 3'b001;
    localparam logic [2:0] OP_CLEAR = 3'b010;
    localparam logic [2:0] OP_ALGO  = 3'b011;
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_PIXELS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_WRITE,
        S_CLEAR,
        S_ALGO_WAIT,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [31:0]       instr_r;
    logic              start_q;
    logic              start_rise;
    logic [ADDR_W-1:0] clr_cnt;
    logic              err_r, donewrite_r;
    logic [ALGO_W-1:0] algo_sel_r;

    logic              latch_instr, set_err, set_dw, clr_dw, cnt_clr, cnt_inc, latch_sel;
    logic              addr_bad;

    logic [2:0]        opcode;
    logic [ADDR_W-1:0] instr_addr;
    logic [DATA_W-1:0] instr_data;
    logic [ALGO_W-1:0] instr_algo;
    logic              unused_rsvd;

    assign opcode      = instr_r[31:29];
    assign instr_addr  = instr_r[8 +: ADDR_W];
    assign instr_data  = instr_r[0 +: DATA_W];
    assign instr_algo  = instr_r[0 +: ALGO_W];
    assign unused_rsvd = ^instr_r[28:23];
    assign start_rise  = start & ~start_q;

`ifdef PIXEL_BOUNDS_CHECK_EN
    assign addr_bad = (instr_addr >= ADDR_W'(IMG_PIXELS));
`else
    assign addr_bad = 1'b0;
`endif

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        latch_instr = 1'b0;
        set_err     = 1'b0;
        set_dw      = 1'b0;
        clr_dw      = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        latch_sel   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        algo_start  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_rise) begin
                    latch_instr = 1'b1;
                    state_nxt   = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_WRITE: begin
                        if (addr_bad) begin
                            set_err   = 1'b1;
                            state_nxt = S_DONE;
                        end else begin
                            state_nxt = S_WRITE;
                        end
                    end
                    OP_CLEAR: begin
                        cnt_clr   = 1'b1;
                        state_nxt = S_CLEAR;
                    end
                    OP_ALGO: begin
                        algo_start = 1'b1;
                        latch_sel  = 1'b1;
                        state_nxt  = S_ALGO_WAIT;
                    end
                    default: begin
                        set_err   = 1'b1;
                        state_nxt = S_DONE;
                    end
                endcase
            end
            S_WRITE: begin
                mem_wr_en = 1'b1;
                mem_addr  = instr_addr;
                mem_wdata = instr_data;
                set_dw    = 1'b1;
                state_nxt = S_DONE;
            end
            S_CLEAR: begin
                mem_wr_en = 1'b1;
                mem_addr  = clr_cnt;
                // Leave on the cycle that writes the last pixel, so the counter never wraps.
                if (clr_cnt == LAST_PIX) begin
                    state_nxt = S_DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_ALGO_WAIT: begin
                if (algo_done) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (!start) begin
                    clr_dw    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            start_q     <= 1'b0;
            instr_r     <= '0;
            clr_cnt     <= '0;
            err_r       <= 1'b0;
            donewrite_r <= 1'b0;
            algo_sel_r  <= '0;
        end else begin
            start_q <= start;
            if (latch_instr) begin
                instr_r <= instruct;
            end
            if (cnt_clr) begin
                clr_cnt <= '0;
            end else if (cnt_inc) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
            if (latch_instr) begin
                err_r <= 1'b0;
            end else if (set_err) begin
                err_r <= 1'b1;
            end
            if (set_dw) begin
                donewrite_r <= 1'b1;
            end else if (clr_dw) begin
                donewrite_r <= 1'b0;
            end
            if (latch_sel) begin
                algo_sel_r <= instr_algo;
            end
        end
    end

    assign done      = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign err       = err_r;
    assign donewrite = donewrite_r;
    assign algo_sel  = algo_sel_r;

endmodule
